// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if
//   Groups the ROM bus and the decode/execute handshake of the fetch stage.
//   master : fetch stage (drives ROM pins and the instruction to decode)
//   slave  : environment (ROM, decode, execute)
//   rom_address[31:0]   byte address to the ROM
//   rom_chip_select     ROM chip select
//   rom_output_enable   ROM output enable (bus high-Z when low)
//   rom_data[63:0]      ROM data bus, instruction in [31:0]
//   instr[31:0]         captured instruction
//   instr_pc[31:0]      address instr was fetched from
//   instr_valid         instr/instr_pc valid for decode
//   instr_ready         decode accepts instr
//   redirect            taken branch/jump, reload PC
//   redirect_target     new PC (low two bits dropped)
interface instruction_fetch_if;
  logic [31:0] rom_address;
  logic        rom_chip_select;
  logic        rom_output_enable;
  logic [63:0] rom_data;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_target;

  modport master (
    output rom_address, rom_chip_select, rom_output_enable,
    output instr, instr_pc, instr_valid,
    input  rom_data, instr_ready, redirect, redirect_target
  );

  modport slave (
    input  rom_address, rom_chip_select, rom_output_enable,
    input  instr, instr_pc, instr_valid,
    output rom_data, instr_ready, redirect, redirect_target
  );
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch
//   LEGv8 fetch stage. Three-state fetch (address setup, read, hold) against
//   a combinational ROM; the captured word is offered to decode with a
//   valid/ready handshake. Redirects reload the PC and drop any held word.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : instruction_fetch_if.master (ROM pins + decode/execute handshake)
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic                clock,
  input  logic                reset,
  instruction_fetch_if.master bus
);

  typedef enum logic [1:0] {S_ADDR, S_READ, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        valid_q, valid_d;

  // Bits of the bus this stage deliberately ignores.
  logic unused_bits;
  assign unused_bits = ^{bus.rom_data[63:32], bus.redirect_target[1:0]};

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_ADDR;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
    end
  end

  // Next-state logic; redirect wins over everything else.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ADDR:  state_d = S_READ;
      S_READ:  state_d = S_HOLD;
      S_HOLD:  if (bus.instr_ready) state_d = S_ADDR;
      default: state_d = S_ADDR;
    endcase
    if (bus.redirect) state_d = S_ADDR;
  end

  // Datapath next values. rom_data is only looked at in S_READ, so a
  // floating bus in other states never reaches instr.
  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    if (bus.redirect) begin
      pc_d    = {bus.redirect_target[31:2], 2'b00};
      valid_d = 1'b0;
    end else begin
      case (state_q)
        S_READ: begin
          instr_d    = bus.rom_data[31:0];
          instr_pc_d = pc_q;
          pc_d       = pc_q + 32'(PC_STEP);
          valid_d    = 1'b1;
        end
        S_HOLD:  if (bus.instr_ready) valid_d = 1'b0;
        default: ;
      endcase
    end
  end

  // Outputs decoded from registered state only; the reset term keeps the
  // ROM deselected while reset is held even though state sits in S_ADDR.
  always_comb begin
    bus.rom_chip_select   = 1'b0;
    bus.rom_output_enable = 1'b0;
    case (state_q)
      S_ADDR:  bus.rom_chip_select = reset;
      S_READ: begin
        bus.rom_chip_select   = reset;
        bus.rom_output_enable = reset;
      end
      default: ;
    endcase
  end

  assign bus.rom_address = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   total  = 0;
  int   passed = 0;

  instruction_fetch_if ifc ();

  instruction_fetch #(.RESET_PC(32'h0), .PC_STEP(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc)
  );

  always #5 clock = ~clock;

  // ROM: 0x91002BE0 at 0x0, otherwise 0xF8000000|addr; junk upper half;
  // bus floats when output enable is low.
  assign ifc.rom_data = ifc.rom_output_enable
    ? {32'hDEAD_BEEF, (ifc.rom_address == 32'h0) ? 32'h9100_2BE0
                                                 : (32'hF800_0000 | ifc.rom_address)}
    : 64'bz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  initial begin
    ifc.instr_ready     = 1'b0;
    ifc.redirect        = 1'b0;
    ifc.redirect_target = 32'h0;

    // Held in reset
    step(); step();
    chk("rst_cs",    32'(ifc.rom_chip_select),   32'h0);
    chk("rst_oe",    32'(ifc.rom_output_enable), 32'h0);
    chk("rst_valid", 32'(ifc.instr_valid),       32'h0);
    chk("rst_instr", ifc.instr,                  32'h0);
    chk("rst_ipc",   ifc.instr_pc,               32'h0);
    chk("rst_addr",  ifc.rom_address,            32'h0);

    // Release: cycle 1 address setup, cycle 2 read, then valid
    reset = 1'b1; #1;
    chk("c1_cs",   32'(ifc.rom_chip_select),   32'h1);
    chk("c1_oe",   32'(ifc.rom_output_enable), 32'h0);
    chk("c1_addr", ifc.rom_address,            32'h0);
    step();
    chk("c2_oe", 32'(ifc.rom_output_enable), 32'h1);
    chk("c2_cs", 32'(ifc.rom_chip_select),   32'h1);
    step();
    chk("first_valid", 32'(ifc.instr_valid), 32'h1);
    chk("first_instr", ifc.instr,            32'h9100_2BE0);
    chk("first_ipc",   ifc.instr_pc,         32'h0);

    // Backpressure: 5 cycles of hold, ROM idle
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", 32'(ifc.instr_valid),     32'h1);
      chk("bp_instr", ifc.instr,                32'h9100_2BE0);
      chk("bp_ipc",   ifc.instr_pc,             32'h0);
      chk("bp_cs",    32'(ifc.rom_chip_select), 32'h0);
    end
    ifc.instr_ready = 1'b1;
    step();
    chk("acc_valid", 32'(ifc.instr_valid), 32'h0);
    chk("acc_addr",  ifc.rom_address,      32'h4);

    // Sequential stream, one word per 3 cycles
    for (int k = 0; k < 3; k++) begin
      step();
      chk("seq_read_valid", 32'(ifc.instr_valid), 32'h0);
      step();
      chk("seq_valid", 32'(ifc.instr_valid), 32'h1);
      chk("seq_ipc",   ifc.instr_pc,         32'(4 * (k + 1)));
      step();
      chk("seq_gap", 32'(ifc.instr_valid), 32'h0);
    end
    chk("seq_next_addr", ifc.rom_address, 32'h10);
    ifc.instr_ready = 1'b0;

    // Redirect during S_READ: no capture, PC aligned to 0x14
    step();
    chk("rd_oe", 32'(ifc.rom_output_enable), 32'h1);
    ifc.redirect = 1'b1; ifc.redirect_target = 32'h16;
    step();
    ifc.redirect = 1'b0;
    chk("rd_valid", 32'(ifc.instr_valid),       32'h0);
    chk("rd_addr",  ifc.rom_address,            32'h14);
    chk("rd_ipc",   ifc.instr_pc,               32'hC);
    chk("rd_instr", ifc.instr,                  32'hF800_000C);
    chk("rd_oe0",   32'(ifc.rom_output_enable), 32'h0);
    step(); step();
    chk("rd_tgt_valid", 32'(ifc.instr_valid), 32'h1);
    chk("rd_tgt_ipc",   ifc.instr_pc,         32'h14);
    chk("rd_tgt_instr", ifc.instr,            32'hF800_0014);

    // Redirect from S_HOLD to the top of memory, then wrap
    ifc.redirect = 1'b1; ifc.redirect_target = 32'hFFFF_FFFC;
    step();
    ifc.redirect = 1'b0;
    chk("wr_valid", 32'(ifc.instr_valid), 32'h0);
    chk("wr_addr",  ifc.rom_address,      32'hFFFF_FFFC);
    step(); step();
    chk("wr_ipc",   ifc.instr_pc, 32'hFFFF_FFFC);
    chk("wr_instr", ifc.instr,    32'hFFFF_FFFC);
    ifc.instr_ready = 1'b1;
    step();
    chk("wrap_addr", ifc.rom_address, 32'h0);
    step(); step();
    chk("wrap_ipc", ifc.instr_pc, 32'h0);
    step();
    chk("pre_rst_addr", ifc.rom_address, 32'h4);
    step();
    chk("pre_rst_oe", 32'(ifc.rom_output_enable), 32'h1);

    // Asynchronous reset mid-S_READ
    ifc.instr_ready = 1'b0;
    #2 reset = 1'b0; #1;
    chk("ar_addr",  ifc.rom_address,            32'h0);
    chk("ar_cs",    32'(ifc.rom_chip_select),   32'h0);
    chk("ar_oe",    32'(ifc.rom_output_enable), 32'h0);
    chk("ar_valid", 32'(ifc.instr_valid),       32'h0);
    chk("ar_instr", ifc.instr,                  32'h0);
    chk("ar_ipc",   ifc.instr_pc,               32'h0);
    step();
    reset = 1'b1; #1;
    chk("rs_cs", 32'(ifc.rom_chip_select), 32'h1);
    step();
    chk("rs_oe", 32'(ifc.rom_output_enable), 32'h1);
    step();
    chk("rs_valid", 32'(ifc.instr_valid), 32'h1);
    chk("rs_instr", ifc.instr,            32'h9100_2BE0);
    chk("rs_ipc",   ifc.instr_pc,         32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
